addsub_arbiter: RTL and testbench

//   Shares one 8-bit adder_subtractor datapath between two requesters. Round-robin arbitration.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/adder_subtractor.sv | 13 +
 rtl/addsub_rr_arb2.sv | 37 +++
 rtl/addsub_arbiter.sv | 147 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/subtract arbiter.
package addsub_pkg;

  localparam int ADDSUB_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_subtractor.sv
// Plain combinational datapath: result = a + b, or a - b when subtract is set.
module adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic [WIDTH-1:0] result
);

  assign result = subtract ? (a - b) : (a + b);

endmodule

// File: rtl/addsub_rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester favoured on a tie.
module addsub_rr_arb2
  import addsub_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic upd_id_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic ptr_o
);

  logic ptr_q;
  logic ptr_d;

  // After a served request the other requester becomes favoured.
  assign ptr_d  = upd_i ? ~upd_id_i : ptr_q;

  assign gnt0_o = en_i & req0_i & (~req1_i | (ptr_q == REQ0));
  assign gnt1_o = en_i & req1_i & (~req0_i | (ptr_q == REQ1));
  assign ptr_o  = ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= RR_INIT;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one adder_subtractor between two requesters; returns tagged result,
// carry/borrow and signed overflow over a valid/ready response channel.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH   = ADDSUB_W,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic [1:0]       dbg_state_o,
  output logic             dbg_ptr_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Requesters hold valid and operands until ready; rsp_* stay stable while
  // rsp_valid && !rsp_ready.

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_sub_q;
  logic             op_id_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_carry_q;
  logic             rsp_overflow_q;

  logic             gnt0;
  logic             gnt1;
  logic             rsp_hs;
  logic [WIDTH-1:0] dp_result;
  logic [WIDTH:0]   ext;
  logic             ovf;

  assign rsp_hs = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;

  addsub_rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     ((state_q == ST_IDLE) && rst_n),
    .req0_i   (req0_valid),
    .req1_i   (req1_valid),
    .upd_i    (rsp_hs),
    .upd_id_i (rsp_id_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .ptr_o    (dbg_ptr_o)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  adder_subtractor #(
    .WIDTH (WIDTH)
  ) u_dp (
    .a        (op_a_q),
    .b        (op_b_q),
    .subtract (op_sub_q),
    .result   (dp_result)
  );

  // One extra bit gives carry-out on add and borrow (a < b) on subtract.
  assign ext = (op_sub_q == OP_SUB) ? ({1'b0, op_a_q} - {1'b0, op_b_q})
                                    : ({1'b0, op_a_q} + {1'b0, op_b_q});

  assign ovf = (op_sub_q == OP_SUB)
             ? ((op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) && (dp_result[WIDTH-1] != op_a_q[WIDTH-1]))
             : ((op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (dp_result[WIDTH-1] != op_a_q[WIDTH-1]));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_sub_q       <= OP_ADD;
      op_id_q        <= REQ0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= REQ0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            op_a_q   <= gnt1 ? req1_a   : req0_a;
            op_b_q   <= gnt1 ? req1_b   : req0_b;
            op_sub_q <= gnt1 ? req1_sub : req0_sub;
            op_id_q  <= gnt1 ? REQ1     : REQ0;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q   <= dp_result;
          rsp_carry_q    <= ext[WIDTH];
          rsp_overflow_q <= ovf;
          rsp_id_q       <= op_id_q;
          rsp_valid_q    <= 1'b1;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_overflow_q;
  assign dbg_state_o  = state_q;

  a_one_ready : assert property (@(posedge clk) !(req0_ready && req1_ready));

  a_rsp_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_result)
                                   && $stable(rsp_carry) && $stable(rsp_overflow)));

  a_dp_match : assert property (@(posedge clk) dp_result == ext[WIDTH-1:0]);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: drivers push expected responses on accept,
// a negedge monitor pops and compares every response handshake.
module tb_addsub_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_sub;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [7:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_overflow;
  logic [7:0] rsp_result;
  logic [1:0] dbg_state;
  logic       dbg_ptr;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] exp_q[$];
  logic        acc_ids[$];
  bit          track_acc = 0;

  addsub_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_sub     (req0_sub),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_sub     (req1_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .dbg_state_o  (dbg_state),
    .dbg_ptr_o    (dbg_ptr)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input logic id, input logic [7:0] r,
                                     input logic c, input logic v);
    return {id, r, c, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Driver: present an op, wait (bounded) for ready, push expected on accept.
  // Returns 1ns after the accepting edge with valid still asserted.
  task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic [10:0] exp);
    if (id) begin
      req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id && req1_ready) || (!id && req0_ready)) begin
        exp_q.push_back(exp);
        if (track_acc) acc_ids.push_back(id);
        @(posedge clk);
        #1;
        return;
      end
    end
    check(id ? "req1_accept_timeout" : "req0_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !rsp_valid) return;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got %0h, expected no response",
                   {rsp_id, rsp_result, rsp_carry, rsp_overflow});
        end else begin
          check("rsp", {21'd0, rsp_id, rsp_result, rsp_carry, rsp_overflow},
                {21'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_ptr", {31'd0, dbg_ptr}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add with latency check
    drive(1'b0, 8'hCC, 8'h33, 1'b0, pk(1'b0, 8'hFF, 1'b0, 1'b0));
    req0_valid = 1'b0;
    check("lat_exec_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_resp_valid", {31'd0, rsp_valid}, 32'd1);

    // Single sub from requester 1
    drive(1'b1, 8'hCC, 8'hB3, 1'b1, pk(1'b1, 8'h19, 1'b0, 1'b0));
    req1_valid = 1'b0;
    wait_drain();

    // Wrap and overflow corners
    drive(1'b0, 8'hFF, 8'h01, 1'b0, pk(1'b0, 8'h00, 1'b1, 1'b0));
    drive(1'b0, 8'h00, 8'h01, 1'b1, pk(1'b0, 8'hFF, 1'b1, 1'b0));
    drive(1'b0, 8'h7F, 8'h01, 1'b0, pk(1'b0, 8'h80, 1'b0, 1'b1));
    drive(1'b0, 8'h80, 8'h01, 1'b1, pk(1'b0, 8'h7F, 1'b0, 1'b1));
    req0_valid = 1'b0;
    wait_drain();

    // Contention from reset: both held valid, grants must alternate 0,1,0,1
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    track_acc = 1;
    fork
      begin
        drive(1'b0, 8'h10, 8'h20, 1'b0, pk(1'b0, 8'h30, 1'b0, 1'b0));
        drive(1'b0, 8'h90, 8'h90, 1'b0, pk(1'b0, 8'h20, 1'b1, 1'b1));
        req0_valid = 1'b0;
      end
      begin
        drive(1'b1, 8'h50, 8'h30, 1'b1, pk(1'b1, 8'h20, 1'b0, 1'b0));
        drive(1'b1, 8'h05, 8'h0A, 1'b1, pk(1'b1, 8'hFB, 1'b1, 1'b0));
        req1_valid = 1'b0;
      end
    join
    track_acc = 0;
    wait_drain();
    check("grant_count", 32'(acc_ids.size()), 32'd4);
    if (acc_ids.size() == 4) begin
      check("grant_seq", {28'd0, acc_ids[0], acc_ids[1], acc_ids[2], acc_ids[3]}, 32'b0101);
    end

    // Backpressure: hold rsp_ready low for 5 cycles with requester 1 waiting
    rsp_ready = 1'b0;
    drive(1'b0, 8'h40, 8'h40, 1'b0, pk(1'b0, 8'h80, 1'b0, 1'b1));
    req0_valid = 1'b0;
    req1_a = 8'h03; req1_b = 8'h04; req1_sub = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("bp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_rsp", {21'd0, rsp_id, rsp_result, rsp_carry, rsp_overflow},
              {21'd0, pk(1'b0, 8'h80, 1'b0, 1'b1)});
      end
      check("bp_no_accept", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drive(1'b1, 8'h03, 8'h04, 1'b0, pk(1'b1, 8'h07, 1'b0, 1'b0));
    req1_valid = 1'b0;
    wait_drain();

    // Reset mid-op: move pointer off RR_INIT first, then reset during EXEC
    drive(1'b0, 8'h01, 8'h01, 1'b0, pk(1'b0, 8'h02, 1'b0, 1'b0));
    req0_valid = 1'b0;
    wait_drain();
    check("ptr_after_req0", {31'd0, dbg_ptr}, 32'd1);
    drive(1'b0, 8'h11, 8'h22, 1'b0, pk(1'b0, 8'h33, 1'b0, 1'b0));
    req0_valid = 1'b0;
    check("mid_state_exec", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ptr", {31'd0, dbg_ptr}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_valid", {31'd0, rsp_valid}, 32'd0);
    req0_a = 8'h01; req0_b = 8'h02; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 8'hF0; req1_b = 8'h10; req1_sub = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'b10);
    drive(1'b0, 8'h01, 8'h02, 1'b0, pk(1'b0, 8'h03, 1'b0, 1'b0));
    req0_valid = 1'b0;
    drive(1'b1, 8'hF0, 8'h10, 1'b1, pk(1'b1, 8'hE0, 1'b0, 1'b0));
    req1_valid = 1'b0;
    wait_drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
